// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//
// Memory-mapped 128-byte transmit FIFO drained by an 8N1 serializer.
// The core pushes bytes with stores into the decoded region and can read a
// status word. The serializer pops one byte at a time and shifts it out
// LSB first. Consecutive frames follow each other with no idle gap.
//
// Bus handshake: buf_read_i / buf_write_i are single-cycle strobes, qualified
// by the region decode. There is no ready/stall. A store is accepted on the
// edge where it is presented unless the FIFO is full; if full, it is dropped.
// A load returns status on rdata_o one cycle later and never pops the FIFO.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   REGION_SEL    value of addr_i[18:16] that selects this block
// Ports
//   clk                system clock, rising edge
//   rst_i              synchronous active-high reset
//   addr_i             bus address, [18:16] decoded
//   wdata_i            store data, [7:0] used
//   buf_read_i         load strobe
//   buf_write_i        store strobe
//   rdata_o            registered status: {23'b0, busy, count[7:0]} or 0xdeadbeef
//   tx_buffer_full_o   FIFO holds 128 bytes
//   tx_buffer_empty_o  FIFO holds 0 bytes
//   tx_buf_access_o    combinational region access indicator
//   tx_busy_o          serializer not idle
//   uart_tx_o          serial line, registered, idle high
module uart_tx_buffer #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [2:0]  REGION_SEL   = 3'h2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        buf_read_i,
  input  logic        buf_write_i,
  output logic [31:0] rdata_o,
  output logic        tx_buffer_full_o,
  output logic        tx_buffer_empty_o,
  output logic        tx_buf_access_o,
  output logic        tx_busy_o,
  output logic        uart_tx_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [128];
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [7:0]    count;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          region;
  logic          full;
  logic          empty;
  logic          push;
  logic          bit_end;
  logic          unused_bits;

  assign region  = (addr_i[18:16] == REGION_SEL);
  // The extra pointer bit distinguishes full from empty when indices match.
  assign full    = (wr_ptr[6:0] == rd_ptr[6:0]) && (wr_ptr[7] ^ rd_ptr[7]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign push    = region && buf_write_i && !full;
  assign bit_end = (baud_cnt == CNT_LAST);

  assign tx_buffer_full_o  = full;
  assign tx_buffer_empty_o = empty;
  assign tx_buf_access_o   = region && (buf_read_i || buf_write_i);
  assign tx_busy_o         = (state != IDLE);

  assign unused_bits = ^{addr_i[31:19], addr_i[15:0], wdata_i[31:8]};

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[6:0]] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr <= 8'd0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_o <= 32'd0;
    end else if (region && buf_read_i) begin
      rdata_o <= {23'd0, tx_busy_o, count};
    end else begin
      rdata_o <= 32'hdeadbeef;
    end
  end

  // Serializer. Popping uses the registered empty flag, so a byte pushed into
  // an empty FIFO becomes visible to the serializer one cycle later.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state     <= IDLE;
      uart_tx_o <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      rd_ptr    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          baud_cnt  <= '0;
          if (!empty) begin
            shift     <= mem[rd_ptr[6:0]];
            rd_ptr    <= rd_ptr + 8'd1;
            uart_tx_o <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            uart_tx_o <= shift[0];
            bit_idx   <= 3'd0;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= STOP;
            end else begin
              // shift[1] is the bit that becomes shift[0] after this shift.
              shift     <= {1'b0, shift[7:1]};
              uart_tx_o <= shift[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!empty) begin
              shift     <= mem[rd_ptr[6:0]];
              rd_ptr    <= rd_ptr + 8'd1;
              uart_tx_o <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          uart_tx_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer. A fast instance (4 clocks/bit, region 2)
// covers framing, status and reset; a slow instance (512 clocks/bit,
// region 3) keeps its serializer parked on one byte while the FIFO is
// filled to its limit. Both share the bus; the region decode separates them.
module tb_uart_tx_buffer;

  logic        clk;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        buf_read_i;
  logic        buf_write_i;

  logic [31:0] rdata_o;
  logic        full_o, empty_o, access_o, busy_o, tx_o;
  logic [31:0] b_rdata_o;
  logic        b_full_o, b_empty_o, b_access_o, b_busy_o, b_tx_o;

  int checks   = 0;
  int failures = 0;

  uart_tx_buffer #(.CLKS_PER_BIT(4), .REGION_SEL(3'h2)) dut (
    .clk(clk), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .buf_read_i(buf_read_i), .buf_write_i(buf_write_i),
    .rdata_o(rdata_o), .tx_buffer_full_o(full_o), .tx_buffer_empty_o(empty_o),
    .tx_buf_access_o(access_o), .tx_busy_o(busy_o), .uart_tx_o(tx_o)
  );

  uart_tx_buffer #(.CLKS_PER_BIT(512), .REGION_SEL(3'h3)) dut_slow (
    .clk(clk), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .buf_read_i(buf_read_i), .buf_write_i(buf_write_i),
    .rdata_o(b_rdata_o), .tx_buffer_full_o(b_full_o), .tx_buffer_empty_o(b_empty_o),
    .tx_buf_access_o(b_access_o), .tx_busy_o(b_busy_o), .uart_tx_o(b_tx_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    buf_read_i  = 1'b0;
    buf_write_i = 1'b0;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
  endtask

  // Checks one full 40-cycle frame, starting at the sample point just after
  // the pop edge; returns at the sample point 40 cycles later.
  task automatic check_frame(input logic [7:0] b, input string name);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (tx_o !== frame[k/4] || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b expected tx=%b busy=1",
                 name, k, tx_o, busy_o, frame[k/4]);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus_idle();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0 ||
        rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: tx=%b busy=%b empty=%b full=%b rdata=%h expected 1 0 1 0 00000000",
               tx_o, busy_o, empty_o, full_o, rdata_o);
    end
    checks++;
    if (b_tx_o !== 1'b1 || b_empty_o !== 1'b1 || b_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_slow: tx=%b empty=%b rdata=%h expected 1 1 00000000",
               b_tx_o, b_empty_o, b_rdata_o);
    end
    rst_i = 1'b0;
    addr_i = 32'h20000;
    buf_read_i = 1'b1;
    tick();
    checks++;
    if (rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_read: rdata=%h expected 00000000", rdata_o);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_single_byte();
    addr_i = 32'h20000;
    wdata_i = 32'h000000a5;
    buf_write_i = 1'b1;
    tick();
    bus_idle();
    checks++;
    if (empty_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_pushed: empty=%b tx=%b busy=%b expected 0 1 0", empty_o, tx_o, busy_o);
    end
    tick();
    checks++;
    if (empty_o !== 1'b1) begin
      failures++;
      $display("FAIL single_empty_after_pop: empty=%b expected 1", empty_o);
    end
    check_frame(8'ha5, "single_a5");
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL single_end: tx=%b busy=%b empty=%b expected 1 0 1", tx_o, busy_o, empty_o);
    end
  endtask

  task automatic test_back_to_back();
    addr_i = 32'h20000;
    buf_write_i = 1'b1;
    wdata_i = 32'h00;
    tick();
    wdata_i = 32'hff;
    tick();
    bus_idle();
    check_frame(8'h00, "b2b_first");
    check_frame(8'hff, "b2b_second");
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: tx=%b busy=%b empty=%b expected 1 0 1", tx_o, busy_o, empty_o);
    end
  endtask

  task automatic test_status();
    addr_i = 32'h10000;
    wdata_i = 32'h55;
    buf_write_i = 1'b1;
    #1;
    checks++;
    if (access_o !== 1'b0) begin
      failures++;
      $display("FAIL nonregion_access: access=%b expected 0", access_o);
    end
    tick();
    checks++;
    if (empty_o !== 1'b1 || b_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL nonregion_push: empty=%b slow_empty=%b expected 1 1", empty_o, b_empty_o);
    end
    addr_i = 32'h20000;
    #1;
    checks++;
    if (access_o !== 1'b1) begin
      failures++;
      $display("FAIL region_access: access=%b expected 1", access_o);
    end
    for (int i = 0; i < 4; i++) begin
      wdata_i = 32'h11 * (i + 1);
      tick();
    end
    buf_write_i = 1'b0;
    buf_read_i = 1'b1;
    tick();
    checks++;
    if (rdata_o !== 32'h103) begin
      failures++;
      $display("FAIL status_read: rdata=%h expected 00000103", rdata_o);
    end
    addr_i = 32'h10000;
    tick();
    checks++;
    if (rdata_o !== 32'hdeadbeef) begin
      failures++;
      $display("FAIL nonregion_read: rdata=%h expected deadbeef", rdata_o);
    end
    bus_idle();
    repeat (170) tick();
    checks++;
    if (empty_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
      failures++;
      $display("FAIL status_drain: empty=%b busy=%b tx=%b expected 1 0 1", empty_o, busy_o, tx_o);
    end
  endtask

  task automatic test_full_boundary();
    addr_i = 32'h30000;
    wdata_i = 32'h5a;
    buf_write_i = 1'b1;
    tick();
    buf_write_i = 1'b0;
    tick();
    checks++;
    if (b_busy_o !== 1'b1 || b_empty_o !== 1'b1 || b_tx_o !== 1'b0) begin
      failures++;
      $display("FAIL full_first_in_flight: busy=%b empty=%b tx=%b expected 1 1 0",
               b_busy_o, b_empty_o, b_tx_o);
    end
    buf_write_i = 1'b1;
    for (int i = 0; i < 129; i++) begin
      wdata_i = i;
      tick();
      if (i == 126) begin
        checks++;
        if (b_full_o !== 1'b0) begin
          failures++;
          $display("FAIL full_at_127: full=%b expected 0", b_full_o);
        end
      end
      if (i == 127 || i == 128) begin
        checks++;
        if (b_full_o !== 1'b1) begin
          failures++;
          $display("FAIL full_store_%0d: full=%b expected 1", i + 1, b_full_o);
        end
      end
    end
    buf_write_i = 1'b0;
    buf_read_i = 1'b1;
    tick();
    checks++;
    if (b_rdata_o !== 32'h180) begin
      failures++;
      $display("FAIL full_status: rdata=%h expected 00000180", b_rdata_o);
    end
    checks++;
    if (empty_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL full_isolation: fast empty=%b busy=%b expected 1 0", empty_o, busy_o);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int highs;
    addr_i = 32'h20000;
    buf_write_i = 1'b1;
    wdata_i = 32'h00;
    tick();
    wdata_i = 32'h00;
    tick();
    bus_idle();
    repeat (12) tick();
    checks++;
    if (busy_o !== 1'b1 || tx_o !== 1'b0) begin
      failures++;
      $display("FAIL midframe_in_data: busy=%b tx=%b expected 1 0", busy_o, tx_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (tx_o !== 1'b1 || empty_o !== 1'b1 || busy_o !== 1'b0 || b_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL midframe_reset: tx=%b empty=%b busy=%b slow_empty=%b expected 1 1 0 1",
               tx_o, empty_o, busy_o, b_empty_o);
    end
    rst_i = 1'b0;
    highs = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx_o === 1'b1 && busy_o === 1'b0) highs++;
    end
    checks++;
    if (highs != 60) begin
      failures++;
      $display("FAIL midframe_quiet: idle_cycles=%0d expected 60", highs);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus_idle();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_status();
    test_full_boundary();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
